// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: three-stage Kogge-Stone adder with valid/ready handshake.
// S0 registers bitwise generate/propagate (carry-in folded in as bit -1),
// S1 runs the first half of the prefix levels, S2 the rest plus sum/flags.
// Optional subtract mode: define PREFIX_SUB_EN to add the 'sub' port.
module prefix_adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PREFIX_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Vector index 0 is the carry-in pseudo-bit; index i+1 is operand bit i.
  localparam int N = WIDTH + 1;
  localparam int L = $clog2(N);
  localparam int H = (L + 1) / 2;

  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] p;
  } gp_t;

  // Kogge-Stone levels lo..hi; level k combines with the node 2^(k-1) below.
  function automatic gp_t ks_levels(input gp_t x, input int lo, input int hi);
    gp_t y;
    gp_t t;
    int  d;
    y = x;
    for (int k = lo; k <= hi; k++) begin
      d = 1 << (k - 1);
      t = y;
      for (int i = 0; i < N; i++) begin
        if (i >= d) begin
          t.g[i] = y.g[i] | (y.p[i] & y.g[i-d]);
          t.p[i] = y.p[i] & y.p[i-d];
        end
      end
      y = t;
    end
    return y;
  endfunction

  // Final stage only needs the group generates (= carries).
  function automatic logic [N-1:0] ks_carry(input gp_t x, input int lo, input int hi);
    gp_t y;
    y = ks_levels(x, lo, hi);
    return y.g;
  endfunction

  logic [2:0]       vld_pipe;
  logic             rdy0, rdy1, rdy2;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  gp_t              s0_gp, s1_gp, lvl1;
  logic [WIDTH-1:0] s1_pb;
  logic [N-1:0]     carry;

  // Operand conditioning: subtract is a + ~b + 1, with the +1 as carry-in.
`ifdef PREFIX_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  // Each stage advances when empty or when the stage after it advances.
  assign rdy2     = !vld_pipe[2] || out_ready;
  assign rdy1     = !vld_pipe[1] || rdy2;
  assign rdy0     = !vld_pipe[0] || rdy1;
  assign in_ready = rdy0 && !rst;

  assign lvl1  = ks_levels(s0_gp, 1, H);
  assign carry = ks_carry(s1_gp, H + 1, L);

  assign out_valid = vld_pipe[2];

  // Pipeline registers; stalled stages hold, reset drops all in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s        <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      if (rdy0) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) begin
          s0_gp.g <= {a & b_eff, c_eff};
          s0_gp.p <= {a ^ b_eff, 1'b0};
        end
      end
      if (rdy1) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) begin
          s1_gp <= lvl1;
          s1_pb <= s0_gp.p[N-1:1];
        end
      end
      if (rdy2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s    <= s1_pb ^ carry[N-2:0];
          cout <= carry[N-1];
          ovf  <= carry[N-1] ^ carry[N-2];
          zero <= ((s1_pb ^ carry[N-2:0]) == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: 8-bit and 13-bit instances, each stimulated
// in turn against an arithmetic reference model and an in-order scoreboard.
module tb_prefix_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, ov8, or8 = 1, cin8 = 0, sub8 = 0, co8, ovf8, z8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        iv13 = 0, ir13, ov13, or13 = 1, cin13 = 0, sub13 = 0, co13, ovf13, z13;
  logic [12:0] a13 = 0, b13 = 0, s13;

  prefix_adder_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
`ifdef PREFIX_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8), .ovf(ovf8), .zero(z8));

  prefix_adder_pipe #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13), .cin(cin13),
`ifdef PREFIX_SUB_EN
    .sub(sub13),
`endif
    .out_valid(ov13), .out_ready(or13), .s(s13), .cout(co13), .ovf(ovf13), .zero(z13));

  typedef struct {
    logic [12:0] s;
    logic        co, ovf, z;
    int          t;
  } exp_t;

  exp_t q[$];
  int   nerr = 0, nchk = 0, stepn = 0;
  bit   chk_lat = 0;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input bit w13, input logic [12:0] ta, input logic [12:0] tb_,
                                 input logic tc, input logic ts, input int t);
    exp_t   e;
    int     w;
    longint one, mask, ua, ub, sa, sb, tot, r;
    w    = w13 ? 13 : 8;
    one  = 1;
    mask = (one << w) - 1;
    ua   = longint'(ta) & mask;
    ub   = longint'(tb_) & mask;
    sa   = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb   = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    if (ts) begin
      tot = ua + ((~ub) & mask) + 1;
      r   = sa - sb;
    end else begin
      tot = ua + ub + longint'(tc);
      r   = sa + sb + longint'(tc);
    end
    e.s   = 13'(tot & mask);
    e.co  = ((tot >> w) & 1) != 0;
    e.ovf = (r > (one << (w - 1)) - 1) || (r < -(one << (w - 1)));
    e.z   = ((tot & mask) == 0);
    e.t   = t;
    return e;
  endfunction

  // One clock: drive at negedge, check in_ready/outputs, update scoreboard.
  task automatic step(input bit w13, input logic iv, input logic [12:0] ta, input logic [12:0] tb_,
                      input logic tc, input logic ts, input logic orr, output bit acc, output logic ir);
    logic        ov, co, vf, zz;
    logic [12:0] so;
    exp_t        e;
    @(negedge clk);
    if (w13) begin
      iv13 = iv; a13 = ta; b13 = tb_; cin13 = tc; sub13 = ts; or13 = orr;
      iv8 = 0; or8 = 1;
    end else begin
      iv8 = iv; a8 = ta[7:0]; b8 = tb_[7:0]; cin8 = tc; sub8 = ts; or8 = orr;
      iv13 = 0; or13 = 1;
    end
    #1;
    ov = w13 ? ov13 : ov8;
    so = w13 ? s13 : {5'b0, s8};
    co = w13 ? co13 : co8;
    vf = w13 ? ovf13 : ovf8;
    zz = w13 ? z13 : z8;
    ir = w13 ? ir13 : ir8;
    nchk++;
    if (ir !== ((q.size() < 3) || orr)) begin
      nerr++;
      $display("FAIL in_ready step=%0d got=%b want=%b occ=%0d", stepn, ir, (q.size() < 3) || orr, q.size());
    end
    if (ov === 1'b1) begin
      nchk++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL spurious_result step=%0d s=%0d", stepn, so);
      end else begin
        e = q[0];
        if ({so, co, vf, zz} !== {e.s, e.co, e.ovf, e.z}) begin
          nerr++;
          $display("FAIL result step=%0d got s=%0d c=%b v=%b z=%b want s=%0d c=%b v=%b z=%b",
                   stepn, so, co, vf, zz, e.s, e.co, e.ovf, e.z);
        end
        if (orr) begin
          if (chk_lat) begin
            nchk++;
            if (stepn - e.t != 3) begin
              nerr++;
              $display("FAIL latency got=%0d want=3", stepn - e.t);
            end
          end
          void'(q.pop_front());
        end
      end
    end
    acc = iv && (ir === 1'b1);
    if (acc) q.push_back(model(w13, ta, tb_, tc, ts, stepn));
    stepn++;
  endtask

  task automatic drain(input bit w13);
    bit   acc;
    logic ir;
    for (int i = 0; i < 40 && q.size() > 0; i++) step(w13, 0, 0, 0, 0, 0, 1, acc, ir);
    nchk++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; iv8 = 0; iv13 = 0; or8 = 1; or13 = 1;
    #1;
    nchk++;
    if ({ir8, ir13} !== 2'b00) begin
      nerr++;
      $display("FAIL in_ready_during_reset got=%b want=00", {ir8, ir13});
    end
    @(negedge clk);
    rst = 0;
    q.delete();
    #1;
    nchk++;
    if ({ov8, s8, co8, ovf8, z8, ir8} !== {1'b0, 8'd0, 3'b000, 1'b1}) begin
      nerr++;
      $display("FAIL reset_state8 got ov=%b s=%0d c=%b v=%b z=%b ir=%b want ov=0 s=0 c=0 v=0 z=0 ir=1",
               ov8, s8, co8, ovf8, z8, ir8);
    end
    nchk++;
    if ({ov13, s13, ir13} !== {1'b0, 13'd0, 1'b1}) begin
      nerr++;
      $display("FAIL reset_state13 got ov=%b s=%0d ir=%b want ov=0 s=0 ir=1", ov13, s13, ir13);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_stream();
    logic [7:0] av[4] = '{8'd0, 8'd100, 8'd20, 8'd177};
    logic [7:0] bv[4] = '{8'd65, 8'd24, 8'd178, 8'd54};
    bit   acc;
    logic ir;
    chk_lat = 1;
    for (int i = 0; i < 4; i++) step(0, 1, {5'b0, av[i]}, {5'b0, bv[i]}, 0, 0, 1, acc, ir);
    drain(0);
    chk_lat = 0;
  endtask

  task automatic test_flags();
    logic [7:0] av[3] = '{8'd200, 8'd100, 8'd255};
    logic [7:0] bv[3] = '{8'd100, 8'd50, 8'd0};
    logic       cv[3] = '{1'b0, 1'b0, 1'b1};
    bit   acc;
    logic ir;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, {5'b0, av[i]}, {5'b0, bv[i]}, cv[i], 0, 1, acc, ir);
      step(0, 0, 0, 0, 0, 0, 1, acc, ir);
    end
    drain(0);
  endtask

  task automatic test_backpressure();
    logic [7:0] av[8], bv[8];
    int   i = 0, n = 0;
    bit   acc, blocked = 0;
    logic ir;
    for (int k = 0; k < 8; k++) begin
      av[k] = 8'($urandom);
      bv[k] = 8'($urandom);
    end
    while (i < 8 && n < 60) begin
      step(0, 1, {5'b0, av[i]}, {5'b0, bv[i]}, 1'(i), 0, !(n >= 3 && n < 7), acc, ir);
      if (acc) i++;
      if (ir === 1'b0) blocked = 1;
      n++;
    end
    nchk++;
    if (!blocked || i != 8) begin
      nerr++;
      $display("FAIL backpressure blocked=%b issued=%0d want blocked=1 issued=8", blocked, i);
    end
    drain(0);
  endtask

  task automatic test_reset_midflight();
    bit   acc;
    logic ir;
    for (int i = 0; i < 3; i++) step(0, 1, 13'(10 + i), 13'(20), 0, 0, 0, acc, ir);
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, acc, ir);
  endtask

  task automatic test_random13();
    int   issued = 0;
    bit   acc;
    logic ir;
    for (int n = 0; n < 10000 && issued < 1000; n++) begin
      step(1, ($urandom % 4) != 0, 13'($urandom), 13'($urandom), 1'($urandom),
           0, ($urandom % 4) != 0, acc, ir);
      if (acc) issued++;
    end
    nchk++;
    if (issued != 1000) begin
      nerr++;
      $display("FAIL random_issue got=%0d want=1000", issued);
    end
    drain(1);
  endtask

`ifdef PREFIX_SUB_EN
  task automatic test_sub();
    logic [7:0] av[3] = '{8'd100, 8'd24, 8'd128};
    logic [7:0] bv[3] = '{8'd24, 8'd100, 8'd1};
    bit   acc;
    logic ir;
    for (int i = 0; i < 3; i++) step(0, 1, {5'b0, av[i]}, {5'b0, bv[i]}, 1'b0, 1, 1, acc, ir);
    for (int i = 0; i < 20; i++)
      step(0, 1, 13'($urandom), 13'($urandom), 1'($urandom), 1'($urandom), ($urandom % 3) != 0, acc, ir);
    drain(0);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_flags();
    test_backpressure();
    test_reset_midflight();
    test_random13();
`ifdef PREFIX_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
